// File: rtl/spi_reg_write_ctrl.sv
// SPI slave that turns one 16-bit frame per chip-select into either a
// register readback on miso or a setup/latch write strobe on latch_en.
module spi_reg_write_ctrl #(
    parameter int         NUM_REGS     = 16,
    parameter int         LATCH_CYCLES = 2,
    parameter logic [7:0] RESET_DATA   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire                   DVDD,
    inout  wire                   DVSS,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [8*NUM_REGS-1:0] reg_rdata,
    output logic [7:0]            wdata,
    output logic [NUM_REGS-1:0]   latch_en,
    output logic                  addr_err
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_SETUP, S_LATCH, S_DONE} state_t;

    // Power pins have no logic function; fold them into a sink.
    wire unused_pwr = DVDD ^ DVSS;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic csn_meta_q, csn_sync_q, csn_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t                state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            shift_q, shift_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [6:0]            tx_q, tx_d;
    logic [3:0]            lat_cnt_q, lat_cnt_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [NUM_REGS-1:0]   latch_en_q, latch_en_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  addr_err_q, addr_err_d;

    logic                  sclk_rise, sclk_fall, csn_fall;
    logic [7:0]            rx_byte;
    logic                  rx_in_range;
    logic [NUM_REGS-1:0]   sel_onehot;
    logic [7:0]            rd_byte;

    assign sclk_rise   = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q & sclk_prev_q;
    assign csn_fall    = csn_prev_q & ~csn_sync_q;
    // Byte as it stands including the bit arriving on this edge.
    assign rx_byte     = {shift_q, mosi_sync_q};
    assign rx_in_range = ({1'b0, rx_byte[6:0]} < 8'(NUM_REGS));

    // Decode the latched command address; out-of-range addresses match nothing and read 0.
    always_comb begin
        sel_onehot = '0;
        rd_byte    = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_q[6:0] == 7'(i)) begin
                sel_onehot[i] = 1'b1;
                rd_byte       = reg_rdata[8*i +: 8];
            end
        end
    end

    // Synchronize the SPI pins and keep one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            csn_meta_q  <= 1'b1;
            csn_sync_q  <= 1'b1;
            csn_prev_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            csn_meta_q  <= csn;
            csn_sync_q  <= csn_meta_q;
            csn_prev_q  <= csn_sync_q;
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Frame FSM next state and registered outputs.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        lat_cnt_d  = lat_cnt_q;
        wdata_d    = wdata_q;
        latch_en_d = latch_en_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        addr_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A sclk edge coincident with csn falling is deliberately not sampled.
                if (csn_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 5'd0;
                    shift_d   = 7'd0;
                end
            end
            S_CMD: begin
                if (csn_sync_q) begin
                    state_d = S_IDLE;
                end else if (sclk_rise) begin
                    shift_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        cmd_d      = rx_byte;
                        state_d    = S_DATA;
                        addr_err_d = ~rx_in_range;
                    end
                end
            end
            S_DATA: begin
                if (csn_sync_q) begin
                    state_d   = S_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else begin
                    if (sclk_fall && !cmd_q[7]) begin
                        // First falling edge of the data byte captures the readback.
                        if (bit_cnt_q == 5'd8) begin
                            miso_d    = rd_byte[7];
                            tx_d      = rd_byte[6:0];
                            miso_oe_d = 1'b1;
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[5:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            miso_d    = 1'b0;
                            miso_oe_d = 1'b0;
                            if (cmd_q[7] && (|sel_onehot)) begin
                                state_d = S_SETUP;
                                wdata_d = rx_byte;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_SETUP: begin
                // wdata has been stable for one cycle; open the strobe.
                state_d    = S_LATCH;
                latch_en_d = sel_onehot;
                lat_cnt_d  = 4'd1;
            end
            S_LATCH: begin
                // csn is ignored here so the strobe is never truncated.
                if (lat_cnt_q == 4'(LATCH_CYCLES)) begin
                    latch_en_d = '0;
                    state_d    = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // Extra bits in the same csn window are dropped here.
                if (csn_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 5'd0;
            shift_q    <= 7'd0;
            cmd_q      <= 8'd0;
            tx_q       <= 7'd0;
            lat_cnt_q  <= 4'd0;
            wdata_q    <= RESET_DATA;
            latch_en_q <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            lat_cnt_q  <= lat_cnt_d;
            wdata_q    <= wdata_d;
            latch_en_q <= latch_en_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign wdata    = wdata_q;
    assign latch_en = latch_en_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_reg_write_ctrl.sv
// Randomized frame-level bench for spi_reg_write_ctrl with a transaction model.
module tb_spi_reg_write_ctrl;
    localparam int         NUM_REGS     = 16;
    localparam int         LATCH_CYCLES = 2;
    localparam logic [7:0] RESET_DATA   = 8'h00;
    localparam int         HALF         = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
    wire  DVDD, DVSS;
    logic miso, miso_oe, addr_err;
    logic [8*NUM_REGS-1:0] reg_rdata;
    logic [7:0]            wdata;
    logic [NUM_REGS-1:0]   latch_en;
    logic [7:0]            regs [NUM_REGS];

    assign DVDD = 1'b1;
    assign DVSS = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        reg_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_rdata[8*i +: 8] = regs[i];
    end

    spi_reg_write_ctrl #(.NUM_REGS(NUM_REGS), .LATCH_CYCLES(LATCH_CYCLES), .RESET_DATA(RESET_DATA)) dut (
        .clk(clk), .rst(rst), .DVDD(DVDD), .DVSS(DVSS),
        .sclk(sclk), .csn(csn), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .reg_rdata(reg_rdata), .wdata(wdata), .latch_en(latch_en), .addr_err(addr_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor-collected events for the frame in progress.
    int                  lat_cnt, lat_len, ae_pulses, ae_cycles;
    logic [NUM_REGS-1:0] lat_vec;
    logic [7:0]          lat_wd, lat_pre1, lat_pre2;

    task automatic clear_mon();
        lat_cnt = 0; lat_len = 0; ae_pulses = 0; ae_cycles = 0;
        lat_vec = '0; lat_wd = 8'h00; lat_pre1 = 8'h00; lat_pre2 = 8'h00;
    endtask

    // Per-cycle output checks and event capture, sampled on the falling clk edge.
    initial begin
        logic [NUM_REGS-1:0] prev_le;
        logic [7:0]          w1, w2;
        logic                prev_ae, rst_q, chg_pending;
        prev_le = '0; w1 = RESET_DATA; w2 = RESET_DATA;
        prev_ae = 1'b0; rst_q = 1'b1; chg_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || rst_q) begin
                prev_le = latch_en; w1 = wdata; w2 = wdata; prev_ae = addr_err;
                chg_pending = 1'b0; rst_q = rst;
            end else begin
                check("latch_onehot", 32'($countones(latch_en) <= 1), 32'd1);
                if (!miso_oe) check("miso_quiet", 32'(miso), 32'd0);
                if (chg_pending) check("latch_after_wdata", 32'(latch_en != '0), 32'd1);
                chg_pending = (wdata != w1);
                if (latch_en != '0) begin
                    if (prev_le == '0) begin
                        lat_cnt++; lat_len = 1; lat_vec = latch_en;
                        lat_wd = wdata; lat_pre1 = w1; lat_pre2 = w2;
                    end else begin
                        lat_len++;
                        check("latch_hold", 32'(latch_en), 32'(prev_le));
                        check("wdata_hold", 32'(wdata), 32'(w1));
                    end
                end
                if (addr_err) ae_cycles++;
                if (addr_err && !prev_ae) ae_pulses++;
                w2 = w1; w1 = wdata; prev_le = latch_en; prev_ae = addr_err; rst_q = 1'b0;
            end
        end
    end

    // Drive one csn window; gap>0 raises csn that many cycles after the last rising sclk.
    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                            input int gap, output logic [7:0] rd, output int oe_hits);
        logic b;
        rd = 8'h00; oe_hits = 0;
        csn = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i < 8)       b = cmd[7-i];
            else if (i < 16) b = dat[15-i];
            else             b = 1'($urandom);
            mosi = b;
            wait_clk(HALF);
            if (i >= 8 && i < 16) begin
                rd[15-i] = miso;
                if (miso_oe) oe_hits++;
            end
            sclk = 1'b1;
            if (i == nbits - 1 && gap > 0) begin
                wait_clk(gap);
                csn = 1'b1;
            end
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        csn = 1'b1; mosi = 1'b0;
        wait_clk(24);
    endtask

    logic [7:0] exp_wdata;

    // Frame-level model: decide latch, addr_err, readback and wdata from the frame contents.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                             input int gap, input string tag, output logic [7:0] rd);
        logic                inr, wr, exp_lat, exp_ae;
        logic [7:0]          exp_rd;
        logic [NUM_REGS-1:0] one;
        int                  oeh;
        inr     = int'(cmd[6:0]) < NUM_REGS;
        wr      = cmd[7];
        exp_ae  = (nbits >= 8) && !inr;
        exp_lat = wr && inr && (nbits >= 16);
        exp_rd  = 8'h00;
        if (inr) exp_rd = regs[cmd[3:0]];
        one = 1;
        clear_mon();
        do_frame(cmd, dat, nbits, gap, rd, oeh);
        check({tag, "_latch_count"}, 32'(lat_cnt), 32'(exp_lat));
        if (exp_lat) begin
            check({tag, "_latch_vec"}, 32'(lat_vec), 32'(one << cmd[6:0]));
            check({tag, "_latch_len"}, 32'(lat_len), 32'(LATCH_CYCLES));
            check({tag, "_latch_wdata"}, 32'(lat_wd), 32'(dat));
            check({tag, "_setup_wdata"}, 32'(lat_pre1), 32'(dat));
            exp_wdata = dat;
        end
        check({tag, "_addr_err"}, 32'(ae_pulses), 32'(exp_ae));
        check({tag, "_addr_err_width"}, 32'(ae_cycles), 32'(exp_ae));
        if (!wr && nbits >= 16) begin
            check({tag, "_read_byte"}, 32'(rd), 32'(exp_rd));
            check({tag, "_read_oe"}, 32'(oeh), 32'd8);
        end
        check({tag, "_wdata"}, 32'(wdata), 32'(exp_wdata));
        check({tag, "_oe_idle"}, 32'(miso_oe), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] c, d, r;
        int         nb, g, p, k, oh;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
        regs[3] = 8'h3C;
        exp_wdata = RESET_DATA;
        clear_mon();

        rst = 1'b1;
        wait_clk(4);
        check("rst_wdata", 32'(wdata), 32'(RESET_DATA));
        check("rst_latch_en", 32'(latch_en), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0;
        wait_clk(4);

        // Basic write to reg5.
        run_frame(8'h85, 8'hA5, 16, 0, "w85", r);
        check("w85_lit_vec", 32'(lat_vec), 32'h0020);
        check("w85_lit_len", 32'(lat_len), 32'd2);
        check("w85_lit_wd", 32'(lat_wd), 32'hA5);
        check("w85_lit_setup", 32'(lat_pre1), 32'hA5);
        check("w85_lit_before", 32'(lat_pre2), 32'h00);

        // Readback of reg3.
        run_frame(8'h03, 8'h00, 16, 0, "r03", r);
        check("r03_lit_byte", 32'(r), 32'h3C);
        check("r03_lit_nolatch", 32'(lat_cnt), 32'd0);

        // Out-of-range write.
        run_frame(8'h90, 8'h11, 16, 0, "w90", r);
        check("w90_lit_ae", 32'(ae_pulses), 32'd1);
        check("w90_lit_nolatch", 32'(lat_cnt), 32'd0);
        check("w90_lit_wdata", 32'(wdata), 32'hA5);

        // Aborted frame followed by a full write.
        run_frame(8'h82, 8'h7E, 12, 0, "w82_abort", r);
        check("w82_abort_lit", 32'(lat_cnt), 32'd0);
        run_frame(8'h82, 8'h7E, 16, 0, "w82", r);
        check("w82_lit_vec", 32'(lat_vec), 32'h0004);
        check("w82_lit_wdata", 32'(wdata), 32'h7E);

        // csn raised right after the last bit must not shorten the strobe.
        run_frame(8'h86, 8'h3A, 16, 1, "w86_early", r);
        check("w86_lit_len", 32'(lat_len), 32'd2);

        // Over-long frame latches once.
        run_frame(8'h84, 8'h55, 24, 0, "w84_long", r);
        check("w84_lit_cnt", 32'(lat_cnt), 32'd1);
        check("w84_lit_vec", 32'(lat_vec), 32'h0010);
        check("w84_lit_wdata", 32'(wdata), 32'h55);

        // Reset in the middle of the strobe.
        clear_mon();
        fork
            do_frame(8'h81, 8'hFF, 16, 1, r, oh);
            begin
                k = 0;
                while (latch_en == '0 && k < 400) begin
                    wait_clk(1);
                    k++;
                end
                check("rst_mid_seen", 32'(latch_en != '0), 32'd1);
                rst = 1'b1;
                wait_clk(1);
                check("rst_mid_latch", 32'(latch_en), 32'd0);
                check("rst_mid_wdata", 32'(wdata), 32'(RESET_DATA));
                wait_clk(1);
                rst = 1'b0;
            end
        join
        exp_wdata = RESET_DATA;
        run_frame(8'h81, 8'h5A, 16, 0, "after_rst", r);
        check("after_rst_lit_vec", 32'(lat_vec), 32'h0002);

        // Randomized frames.
        for (int n = 0; n < 50; n++) begin
            c[7] = 1'($urandom);
            c[6:0] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, NUM_REGS - 1))
                                                 : 7'($urandom_range(0, 127));
            d  = 8'($urandom);
            p  = $urandom_range(0, 99);
            nb = (p < 15) ? $urandom_range(1, 15) : (p < 30) ? 16 + $urandom_range(1, 8) : 16;
            g  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            run_frame(c, d, nb, g, "rnd", r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
